stickman_motion: RTL and testbench



---
 rtl/stickman_motion.sv | 166 ++++++++++++++++
 tb/tb_stickman_motion.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stickman_motion.sv
// Per-frame vertical motion of the stickman: jump impulse, gravity, landing,
// ceiling/floor clamps, and idle/freeze selection driven by the game status.
module stickman_motion #(
    parameter logic [9:0] START_TOP = 10'd370,
    parameter logic [9:0] HEIGHT    = 10'd50,
    parameter logic [9:0] JUMP_V    = 10'd12,
    parameter logic [9:0] GRAVITY   = 10'd1,
    parameter logic [9:0] VMAX      = 10'd12,
    parameter logic [9:0] FLOOR_Y   = 10'd479
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [4:0] status,
    input  logic [9:0] GroundY,
    output logic [9:0] StickmanTop,
    output logic [9:0] Velocity,
    output logic       airborne
);

    // state    | meaning
    // IDLE     | parked at START_TOP (select/waiting screens)
    // GROUNDED | standing on the ground surface
    // AIRBORNE | ballistic motion under gravity
    // FREEZE   | win/lose/unknown status, everything held
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GROUNDED = 2'd1,
        AIRBORNE = 2'd2,
        FREEZE   = 2'd3
    } state_t;

    localparam logic signed [11:0] HEIGHT_S = {2'b00, HEIGHT};
    localparam logic signed [11:0] GRAV_S   = {2'b00, GRAVITY};
    localparam logic signed [11:0] VMAX_S   = {2'b00, VMAX};
    localparam logic signed [11:0] FLOOR_S  = {2'b00, FLOOR_Y};

    state_t      state_q, state_d;
    logic [9:0]  top_q, top_d;
    logic [9:0]  vel_q, vel_d;
    logic        airborne_q, airborne_d;
    logic        jump_armed_q, jump_armed_d;
    logic        frame_clk_q, frame_clk_d;

    logic        tick;
    logic        is_jump;
    logic        st_idle;
    logic        st_play;
    logic        phys_air;
    logic        do_jump;
    logic        do_fall;
    logic        do_land;
    logic        hit_ceiling;
    logic        hit_floor;
    logic        take_jump;

    logic signed [11:0] top_s;
    logic signed [11:0] vel_s;
    logic signed [11:0] gnd_s;
    logic signed [11:0] bot_s;
    logic signed [11:0] next_top_s;
    logic signed [11:0] vel_inc_s;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            top_q        <= START_TOP;
            vel_q        <= 10'd0;
            airborne_q   <= 1'b0;
            jump_armed_q <= 1'b0;
            frame_clk_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            top_q        <= top_d;
            vel_q        <= vel_d;
            airborne_q   <= airborne_d;
            jump_armed_q <= jump_armed_d;
            frame_clk_q  <= frame_clk_d;
        end
    end

    // Frame-rate conditions; arithmetic is widened so bottom+vel cannot wrap.
    always_comb begin
        frame_clk_d = frame_clk;
        tick        = frame_clk & ~frame_clk_q;
        is_jump     = (keycode == 8'h1A) || (keycode == 8'h52);
        st_idle     = (status == 5'b01000) || (status == 5'b10000);
        st_play     = (status == 5'b00100);
        phys_air    = (state_q == AIRBORNE) || ((state_q == FREEZE) && airborne_q);

        top_s       = {2'b00, top_q};
        vel_s       = {{2{vel_q[9]}}, vel_q};
        gnd_s       = {2'b00, GroundY};
        bot_s       = top_s + HEIGHT_S;
        next_top_s  = top_s + vel_s;
        vel_inc_s   = vel_s + GRAV_S;

        do_jump     = is_jump & jump_armed_q;
        do_fall     = gnd_s > bot_s;
        do_land     = (vel_s > 12'sd0) && (bot_s <= gnd_s) && ((bot_s + vel_s) >= gnd_s);
        hit_ceiling = next_top_s < 12'sd0;
        hit_floor   = (next_top_s + HEIGHT_S) >= FLOOR_S;

        take_jump   = tick & st_play & ~phys_air & do_jump;

        if (!is_jump) begin
            jump_armed_d = 1'b1;
        end else if (take_jump) begin
            jump_armed_d = 1'b0;
        end else begin
            jump_armed_d = jump_armed_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (st_idle) begin
                state_d = IDLE;
            end else if (st_play) begin
                if (!phys_air) begin
                    state_d = (do_jump || do_fall) ? AIRBORNE : GROUNDED;
                end else begin
                    state_d = do_land ? GROUNDED : AIRBORNE;
                end
            end else begin
                state_d = FREEZE;
            end
        end
    end

    always_comb begin
        top_d = top_q;
        vel_d = vel_q;
        if (tick) begin
            if (st_idle) begin
                top_d = START_TOP;
                vel_d = 10'd0;
            end else if (st_play) begin
                if (!phys_air) begin
                    vel_d = do_jump ? (10'd0 - JUMP_V) : 10'd0;
                end else if (do_land) begin
                    top_d = GroundY - HEIGHT;
                    vel_d = 10'd0;
                end else if (hit_ceiling) begin
                    top_d = 10'd0;
                    vel_d = 10'd0;
                end else if (hit_floor) begin
                    top_d = FLOOR_Y - HEIGHT;
                    vel_d = 10'd0;
                end else begin
                    top_d = next_top_s[9:0];
                    vel_d = (vel_inc_s > VMAX_S) ? VMAX : vel_inc_s[9:0];
                end
            end
        end
        // Freeze keeps the airborne flag so play can resume in the same mode.
        airborne_d = (state_d == FREEZE) ? airborne_q : (state_d == AIRBORNE);
    end

    assign StickmanTop = top_q;
    assign Velocity    = vel_q;
    assign airborne    = airborne_q;

endmodule

// File: tb/tb_stickman_motion.sv
// Scoreboard bench for stickman_motion: directed scenarios plus random frames
// checked against a plain-integer physics model.
module tb_stickman_motion;

    localparam logic [4:0] ST_SEL  = 5'b10000;
    localparam logic [4:0] ST_WAIT = 5'b01000;
    localparam logic [4:0] ST_PLAY = 5'b00100;
    localparam logic [4:0] ST_LOSE = 5'b00001;
    localparam logic [7:0] K_W     = 8'h1A;
    localparam logic [7:0] K_UP    = 8'h52;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [4:0] status = ST_WAIT;
    logic [9:0] GroundY = 10'd420;
    logic [9:0] StickmanTop;
    logic [9:0] Velocity;
    logic       airborne;

    stickman_motion dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .keycode(keycode),
        .status(status),
        .GroundY(GroundY),
        .StickmanTop(StickmanTop),
        .Velocity(Velocity),
        .airborne(airborne)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        int top;
        int vel;
        int air;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   max_vel = -100;

    // Reference state: position, velocity, in-air flag, jump arming.
    int   m_top = 370;
    int   m_vel = 0;
    bit   m_air = 1'b0;
    bit   m_armed = 1'b0;

    function automatic bit jk(logic [7:0] k);
        return (k == K_W) || (k == K_UP);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_top = 370;
        m_vel = 0;
        m_air = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic model_step(logic [4:0] st, int g, logic [7:0] k);
        int bot;
        int nt;
        bot = m_top + 50;
        nt  = m_top + m_vel;
        if (st == ST_WAIT || st == ST_SEL) begin
            m_top = 370;
            m_vel = 0;
            m_air = 1'b0;
        end else if (st == ST_PLAY) begin
            if (!m_air) begin
                if (jk(k) && m_armed) begin
                    m_vel = -12;
                    m_air = 1'b1;
                    m_armed = 1'b0;
                end else if (g > bot) begin
                    m_vel = 0;
                    m_air = 1'b1;
                end
            end else if (m_vel > 0 && bot <= g && bot + m_vel >= g) begin
                m_top = g - 50;
                m_vel = 0;
                m_air = 1'b0;
            end else if (nt < 0) begin
                m_top = 0;
                m_vel = 0;
            end else if (nt + 50 >= 479) begin
                m_top = 429;
                m_vel = 0;
            end else begin
                m_top = nt;
                m_vel = (m_vel + 1 > 12) ? 12 : m_vel + 1;
            end
        end
    endtask

    task automatic frame(logic [4:0] st, int g, logic [7:0] k);
        @(negedge Clk);
        status  = st;
        GroundY = g[9:0];
        keycode = k;
        if (!jk(k)) m_armed = 1'b1;
        repeat (2) @(negedge Clk);
        model_step(st, g, k);
        sbq.push_back('{m_top, m_vel, int'(m_air)});
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_outputs(string tag, int top, int vel, int air);
        chk({tag, "_top"}, int'(StickmanTop), top);
        chk({tag, "_vel"}, int'($signed(Velocity)), vel);
        chk({tag, "_air"}, int'(airborne), air);
    endtask

    // Monitor: each frame strobe produces one registered update to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            repeat (3) @(posedge Clk);
            #1;
            if (sbq.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_empty: got output with no expected entry at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("sb_top", int'(StickmanTop), e.top);
                chk("sb_vel", int'($signed(Velocity)), e.vel);
                chk("sb_air", int'(airborne), e.air);
                if (int'($signed(Velocity)) > max_vel) max_vel = int'($signed(Velocity));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int frz_top;
        int frz_vel;
        int r;
        int g;
        logic [4:0] st;
        logic [7:0] k;

        repeat (2) @(negedge Clk);
        check_outputs("reset", 370, 0, 0);
        Reset = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) begin
            frame(ST_WAIT, 420, 8'h00);
            chk("idle_top", int'(StickmanTop), 370);
        end

        frame(ST_PLAY, 420, K_W);
        check_outputs("jump1", 370, -12, 1);
        for (int i = 2; i <= 26; i++) begin
            frame(ST_PLAY, 420, K_W);
            if (i == 13) begin
                chk("apex_top", int'(StickmanTop), 292);
                chk("apex_vel", int'($signed(Velocity)), 0);
            end
        end
        chk("land_top", int'(StickmanTop), 370);
        chk("land_air", int'(airborne), 0);

        for (int i = 0; i < 3; i++) begin
            frame(ST_PLAY, 420, K_W);
            chk("held_nojump", int'(airborne), 0);
        end

        @(negedge Clk);
        keycode = 8'h00;
        m_armed = 1'b1;
        @(negedge Clk);
        keycode = K_W;
        frame(ST_PLAY, 420, K_W);
        check_outputs("rejump", 370, -12, 1);
        for (int i = 2; i <= 26; i++) frame(ST_PLAY, 420, K_UP);
        chk("land2_air", int'(airborne), 0);

        frame(ST_PLAY, 479, 8'h00);
        check_outputs("gap", 370, 0, 1);
        for (int i = 0; i < 14; i++) frame(ST_PLAY, 479, 8'h00);
        chk("gap_top", int'(StickmanTop), 429);
        chk("gap_air", int'(airborne), 0);

        frame(ST_WAIT, 420, 8'h00);
        frame(ST_PLAY, 700, K_W);
        for (int i = 0; i < 40; i++) frame(ST_PLAY, 700, 8'h00);
        check_outputs("floor", 429, 0, 1);
        chk("vmax", max_vel, 12);

        frame(ST_WAIT, 420, 8'h00);
        frame(ST_PLAY, 420, 8'h00);
        for (int i = 0; i < 5; i++) begin
            frame(ST_PLAY, 400, 8'h00);
            chk("wall_top", int'(StickmanTop), 370);
        end
        frame(ST_PLAY, 420, K_W);
        for (int i = 0; i < 4; i++) frame(ST_PLAY, 420, 8'h00);
        frz_top = m_top;
        frz_vel = m_vel;
        for (int i = 0; i < 3; i++) frame(ST_LOSE, 420, K_W);
        check_outputs("freeze", frz_top, frz_vel, 1);
        frame(ST_WAIT, 420, 8'h00);
        check_outputs("unfreeze", 370, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       st = ST_PLAY;
            else if (r == 7) st = ST_WAIT;
            else if (r == 8) st = ST_SEL;
            else             st = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: g = 400;
                1: g = 420;
                2: g = 450;
                3: g = 479;
                4: g = 650;
                default: g = $urandom_range(300, 700);
            endcase
            case ($urandom_range(0, 3))
                0: k = 8'h00;
                1: k = K_W;
                2: k = K_UP;
                default: k = 8'h33;
            endcase
            frame(st, g, k);
        end

        frame(ST_WAIT, 420, 8'h00);
        frame(ST_PLAY, 420, K_W);
        for (int i = 0; i < 6; i++) frame(ST_PLAY, 420, 8'h00);
        chk("midair_before_reset", int'(airborne), 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check_outputs("midreset", 370, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        frame(ST_WAIT, 420, 8'h00);

        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
